// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
// Sizing defaults feed both the arbiter and its interface.
package bus_rr_arbiter_pkg;

    localparam int N_CH_DEF        = 8;
    localparam int SEL_W_DEF       = 3;
    localparam int TIMEOUT_CYC_DEF = 1023;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the bus channels, the consumer and the arbiter.
// master = channel/consumer side, slave = arbiter side.
interface bus_rr_arbiter_if
    import bus_rr_arbiter_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
);
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  ch_en;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic             grant_valid;
    logic [N_CH-1:0]  grant_oh;
    logic             timeout;

    modport master (
        output req, ch_en, done,
        input  sel, grant_valid, grant_oh, timeout
    );

    modport slave (
        input  req, ch_en, done,
        output sel, grant_valid, grant_oh, timeout
    );
endinterface

// File: rtl/bus_rr_arbiter_rr_priority_enc.sv
// Rotating priority encoder: first set bit of i_req searching upward from
// i_last+1 with wrap, so the previous winner is considered last.
module rr_priority_enc
    import bus_rr_arbiter_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic [SEL_W-1:0] o_winner,
    output logic             o_found
);
    int w_idx;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = 0;
        for (int i = N_CH; i >= 1; i--) begin
            w_idx = int'(i_last) + i;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (i_req[w_idx[SEL_W-1:0]]) begin
                o_winner = w_idx[SEL_W-1:0];
                o_found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter driving an N_CH:1 bus mux select, with IDLE/GRANT/RELEASE FSM.
// Define ARB_TIMEOUT_EN to add a GRANT watchdog that force-releases after TIMEOUT_CYC cycles.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    bus_rr_arbiter_if.slave  bus
);
    arb_state_t       r_state, w_state_next;
    logic [SEL_W-1:0] r_sel, w_sel_next;
    logic [SEL_W-1:0] r_last_grant, w_last_next;
    logic             r_grant_valid, w_gv_next;
    logic             r_timeout, w_timeout_next;
    logic [SEL_W-1:0] w_winner;
    logic             w_found;

    if (SEL_W < $clog2(N_CH)) begin : g_bad_sel_w
        $error("SEL_W too narrow for N_CH");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    rr_priority_enc #(.N_CH(N_CH), .SEL_W(SEL_W)) u_enc (
        .i_req    (bus.req & bus.ch_en),
        .i_last   (r_last_grant),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wdog, w_wdog_next;
    logic            w_wdog_expire;

    // Counter sits at zero outside GRANT, so it restarts on every new grant.
    assign w_wdog_next   = (r_state == GRANT) ? r_wdog + 1'b1 : '0;
    assign w_wdog_expire = (r_state == GRANT) && (r_wdog == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_next;
        end
    end
`else
    logic w_wdog_expire;
    assign w_wdog_expire = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_last_next    = r_last_grant;
        w_gv_next      = 1'b0;
        w_timeout_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = GRANT;
                    w_sel_next   = w_winner;
                    w_gv_next    = 1'b1;
                end
            end
            GRANT: begin
                w_gv_next = 1'b1;
                // done takes priority over a coincident watchdog expiry.
                if (bus.done || w_wdog_expire) begin
                    w_state_next   = RELEASE;
                    w_gv_next      = 1'b0;
                    w_last_next    = r_sel;
                    w_timeout_next = !bus.done;
                end
            end
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_sel         <= '0;
            r_last_grant  <= SEL_W'(N_CH - 1);
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sel         <= w_sel_next;
            r_last_grant  <= w_last_next;
            r_grant_valid <= w_gv_next;
            r_timeout     <= w_timeout_next;
        end
    end

    assign bus.sel         = r_sel;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_oh    = r_grant_valid ? (N_CH'(1) << r_sel) : '0;
    assign bus.timeout     = r_timeout;
endmodule
